// File: rtl/logo_sprite_engine_if.sv
// Row-lookup bus between the logo sprite engine and an external one-bit logo ROM.
// The ROM is combinational: rom_data must reflect rom_addr within the same cycle.
//   rom_addr : AW-bit row address, driven by the engine (master)
//   rom_data : W-bit row word, MSB = leftmost pixel, driven by the ROM (slave)
interface logo_sprite_engine_if #(
  parameter int W  = 96,
  parameter int AW = 4
);
  logic [AW-1:0] rom_addr;
  logic [W-1:0]  rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/logo_sprite_engine.sv
// Two-stage logo renderer: compares the scan position with the logo placement,
// fetches the logo row from an external ROM and emits a registered per-pixel
// "on" flag. Adds integer scaling (2^S), frame-synchronous blinking and a
// slide-in-from-the-right animation.
// Ports:
//   Clk, Reset_n      : clock, asynchronous active-low reset
//   frame_tick        : one-cycle pulse per frame (vblank start)
//   restart           : one-cycle pulse restarting the animation
//   mode              : bit0 blink enable, bit1 slide-in enable
//   pos_x, pos_y      : final logo top-left corner
//   DrawX, DrawY      : current scan position
//   rom               : ROM row lookup bus (master side)
//   pixel_on          : logo lit at the position sampled two edges earlier
//   busy              : slide in progress
//   done              : one-cycle pulse when a slide lands on pos_x
module logo_sprite_engine #(
  parameter int W            = 96,
  parameter int H            = 16,
  parameter int AW           = 4,
  parameter int S            = 1,
  parameter int SCREEN_W     = 640,
  parameter int SLIDE_STEP   = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_tick,
  input  logic                 restart,
  input  logic [1:0]           mode,
  input  logic [9:0]           pos_x,
  input  logic [9:0]           pos_y,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  logo_sprite_engine_if.master rom,
  output logic                 pixel_on,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [10:0]   X_LIM      = 11'(W << S);
  localparam logic [10:0]   Y_LIM      = 11'(H << S);
  localparam logic [10:0]   PARK_X     = 11'(SCREEN_W);
  localparam logic [11:0]   STEP       = 12'(SLIDE_STEP);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(W - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SLIDE = 1'b1
  } state_t;

  state_t        state;
  logic [10:0]   cur_x;
  logic [10:0]   eff_x;
  logic [10:0]   dx;
  logic [10:0]   dy;
  logic          in1;
  logic [CW-1:0] col1;
  logic [AW-1:0] row1;
  logic          visible;
  logic [BW-1:0] blink_cnt;
  logic [CW-1:0] bit_idx;
  logic [11:0]   next_x;
  logic          step_ends;

  // Horizontal reference: animated position while sliding is enabled, else the fixed one.
  always_comb begin
    if (mode[1]) begin
      eff_x = cur_x;
    end else begin
      eff_x = {1'b0, pos_x};
    end
  end

  // Offsets wrap in 11 bits; bit 10 set means the scan is left of / above the logo.
  assign dx = {1'b0, DrawX} - eff_x;
  assign dy = {1'b0, DrawY} - {1'b0, pos_y};

  assign rom.rom_addr = row1;
  assign bit_idx      = COL_LAST - col1;

  // One-step-ahead position, compared signed so a small pos_x cannot cause a wrap.
  assign next_x    = {1'b0, cur_x} - STEP;
  assign step_ends = ($signed(next_x) <= $signed({2'b00, pos_x}));

  // Stage 1: window test and scaled ROM coordinates.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in1  <= 1'b0;
      col1 <= '0;
      row1 <= '0;
    end else begin
      in1  <= (dx[10] == 1'b0) && (dx < X_LIM) && (dy[10] == 1'b0) && (dy < Y_LIM);
      col1 <= CW'(dx >> S);
      row1 <= AW'(dy >> S);
    end
  end

  // Stage 2: select the ROM bit; col1 is meaningless when in1 is low, hence the gate.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pixel_on <= 1'b0;
    end else begin
      pixel_on <= in1 && visible && rom.rom_data[bit_idx];
    end
  end

  // Slide FSM: restart parks the logo at SCREEN_W, each frame moves it left until pos_x.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cur_x <= PARK_X;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (restart) begin
        if (mode[1]) begin
          state <= SLIDE;
          cur_x <= PARK_X;
          busy  <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          SLIDE: begin
            if (!mode[1]) begin
              // Slide disabled mid-flight: abandon silently.
              state <= IDLE;
              busy  <= 1'b0;
            end else if (frame_tick) begin
              if (step_ends) begin
                state <= IDLE;
                cur_x <= {1'b0, pos_x};
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                cur_x <= next_x[10:0];
              end
            end else begin
              busy <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Blink: toggle visibility every BLINK_FRAMES frames; held on while disabled or sliding.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      blink_cnt <= '0;
      visible   <= 1'b1;
    end else begin
      if (restart || !mode[0] || busy) begin
        blink_cnt <= '0;
        visible   <= 1'b1;
      end else if (frame_tick) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          visible   <= ~visible;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end else begin
        blink_cnt <= blink_cnt;
      end
    end
  end

endmodule

// File: tb/tb_logo_sprite_engine.sv
// Self-checking bench for logo_sprite_engine: random ROM contents, directed
// placement/scaling/slide/blink/reset scenarios and a random pixel stream,
// all compared against a frame-level behavioural model.
module tb_logo_sprite_engine;
  localparam int W = 96, H = 16, AW = 4, S = 1;
  localparam int SCREEN_W = 640, STEP = 4, BF = 30;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [9:0] pos_x = 10'd272;
  logic [9:0] pos_y = 10'd200;
  logic [9:0] DrawX = 10'd0;
  logic [9:0] DrawY = 10'd0;
  logic       pixel_on, busy, done;

  logic [W-1:0] rom [H];

  logo_sprite_engine_if #(.W(W), .AW(AW)) rom_bus ();
  assign rom_bus.rom_data = rom[rom_bus.rom_addr];

  logo_sprite_engine #(
    .W(W), .H(H), .AW(AW), .S(S), .SCREEN_W(SCREEN_W),
    .SLIDE_STEP(STEP), .BLINK_FRAMES(BF)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .restart(restart),
    .mode(mode), .pos_x(pos_x), .pos_y(pos_y), .DrawX(DrawX), .DrawY(DrawY),
    .rom(rom_bus.master), .pixel_on(pixel_on), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Frame-level model of the animation
  int m_cur  = SCREEN_W;
  int m_busy = 0;
  int m_cnt  = 0;
  int m_vis  = 1;

  function automatic int pix_model(input int x, input int y);
    int ex, dxv, dyv;
    ex  = mode[1] ? m_cur : int'(pos_x);
    dxv = x - ex;
    dyv = y - int'(pos_y);
    if (m_vis == 0) return 0;
    if (dxv < 0 || dxv >= W * (1 << S) || dyv < 0 || dyv >= H * (1 << S)) return 0;
    return int'(rom[dyv / (1 << S)][W - 1 - dxv / (1 << S)]);
  endfunction

  task automatic probe(input int x, input int y, input string name);
    int exp;
    DrawX = 10'(x);
    DrawY = 10'(y);
    exp = pix_model(x, y);
    @(posedge Clk); @(posedge Clk); #1;
    checks++;
    if (pixel_on !== exp[0]) begin
      errors++;
      $display("FAIL %s: pixel_on=%b expected %0d at (%0d,%0d)", name, pixel_on, exp, x, y);
    end
  endtask

  task automatic ctl(input logic rs, input logic ft, input string name);
    int prev_busy, exp_done;
    prev_busy = m_busy;
    exp_done = 0;
    if (rs) begin
      if (mode[1]) begin
        m_cur = SCREEN_W;
        m_busy = 1;
      end else begin
        m_busy = 0;
      end
      m_cnt = 0;
      m_vis = 1;
    end else begin
      if (m_busy == 1 && !mode[1]) begin
        m_busy = 0;
      end else if (m_busy == 1 && ft) begin
        if (m_cur - STEP <= int'(pos_x)) begin
          m_cur = int'(pos_x);
          m_busy = 0;
          exp_done = 1;
        end else begin
          m_cur = m_cur - STEP;
        end
      end
      if (!mode[0] || prev_busy == 1) begin
        m_cnt = 0;
        m_vis = 1;
      end else if (ft) begin
        m_cnt++;
        if (m_cnt == BF) begin
          m_cnt = 0;
          m_vis = 1 - m_vis;
        end
      end
    end
    restart = rs;
    frame_tick = ft;
    @(posedge Clk); #1;
    restart = 1'b0;
    frame_tick = 1'b0;
    checks++;
    if (busy !== m_busy[0]) begin
      errors++;
      $display("FAIL %s busy: got %b expected %0d", name, busy, m_busy);
    end
    checks++;
    if (done !== exp_done[0]) begin
      errors++;
      $display("FAIL %s done: got %b expected %0d", name, done, exp_done);
    end
  endtask

  task automatic test_reset();
    @(posedge Clk); #1;
    checks++;
    if ({pixel_on, busy, done} !== 3'b000 || rom_bus.rom_addr !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: pixel_on/busy/done=%b%b%b rom_addr=%0d expected 000 and 0",
               pixel_on, busy, done, rom_bus.rom_addr);
    end
    Reset_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_static();
    mode = 2'b00; pos_x = 10'd272; pos_y = 10'd200;
    probe(272, 204, "static_inside");
    probe(271, 204, "static_left_of_edge");
    probe(464, 204, "static_past_right_edge");
    probe(272, 199, "static_above_top");
    probe(272, 231, "static_bottom_row");
    probe(272, 232, "static_below_bottom");
    DrawX = 10'd272; DrawY = 10'd230;
    @(posedge Clk); #1;
    checks++;
    if (rom_bus.rom_addr !== 4'd15) begin
      errors++;
      $display("FAIL rom_addr_row15: got %0d expected 15", rom_bus.rom_addr);
    end
    DrawY = 10'd200;
    @(posedge Clk); #1;
    checks++;
    if (rom_bus.rom_addr !== 4'd0) begin
      errors++;
      $display("FAIL rom_addr_row0: got %0d expected 0", rom_bus.rom_addr);
    end
    probe(272, 200, "static_row0_blank");
  endtask

  task automatic test_scaling();
    mode = 2'b00; pos_x = 10'd272; pos_y = 10'd200;
    probe(273, 205, "scale_same_bit");
    probe(274, 204, "scale_next_bit");
    probe(463, 231, "scale_last_pixel");
  endtask

  task automatic test_negative();
    mode = 2'b00; pos_x = 10'd600; pos_y = 10'd200;
    probe(10, 204, "negative_offset");
    probe(600, 204, "negative_pos_ref");
  endtask

  task automatic test_stream();
    int exp_q[$];
    int row_q[$];
    int x, y, e, r;
    mode = 2'b00;
    for (int s = 0; s < 3; s++) begin
      pos_x = 10'($urandom_range(0, 800));
      pos_y = 10'($urandom_range(0, 400));
      for (int i = 0; i <= 150; i++) begin
        if (i < 150) begin
          x = int'(pos_x) + $urandom_range(0, 210) - 8;
          y = int'(pos_y) + $urandom_range(0, 40) - 4;
          if (x < 0) x = 0;
          if (y < 0) y = 0;
          DrawX = 10'(x);
          DrawY = 10'(y);
          exp_q.push_back(pix_model(x, y));
          row_q.push_back((((y - int'(pos_y)) & 2047) / (1 << S)) % (1 << AW));
        end
        @(posedge Clk); #1;
        if (i < 150) begin
          r = row_q.pop_front();
          checks++;
          if (rom_bus.rom_addr !== 4'(r)) begin
            errors++;
            $display("FAIL stream_rom_addr: got %0d expected %0d", rom_bus.rom_addr, r);
          end
        end
        if (i >= 1) begin
          e = exp_q.pop_front();
          checks++;
          if (pixel_on !== e[0]) begin
            errors++;
            $display("FAIL stream_pixel: got %b expected %0d (stream %0d step %0d)",
                     pixel_on, e, s, i);
          end
        end
      end
    end
  endtask

  task automatic test_slide();
    int n;
    bit seen;
    mode = 2'b10; pos_x = 10'd272; pos_y = 10'd200;
    ctl(1'b1, 1'b0, "slide_restart");
    n = 0;
    seen = 0;
    while (!seen && n < 200) begin
      ctl(1'b0, 1'b1, "slide_tick");
      n++;
      if (done === 1'b1) seen = 1;
      if (n % 23 == 0) begin
        probe(m_cur, 204, "slide_track_lit");
        probe(m_cur - 1, 204, "slide_track_left");
      end
    end
    checks++;
    if (!seen || n != 92) begin
      errors++;
      $display("FAIL slide_tick_count: done after %0d ticks (seen=%0d) expected 92", n, seen);
    end
    ctl(1'b0, 1'b0, "slide_done_one_cycle");
    probe(272, 204, "slide_landed");
    ctl(1'b1, 1'b0, "slide_restart2");
    repeat (5) ctl(1'b0, 1'b1, "slide2_tick");
    ctl(1'b1, 1'b1, "restart_with_tick");
    probe(640, 204, "restart_tick_park");
    probe(636, 204, "restart_tick_no_step");
  endtask

  task automatic test_mode_drop();
    mode = 2'b10; pos_x = 10'd300; pos_y = 10'd200;
    ctl(1'b1, 1'b0, "drop_restart");
    repeat (3) ctl(1'b0, 1'b1, "drop_tick");
    mode = 2'b00;
    ctl(1'b0, 1'b0, "drop_abort");
    repeat (3) ctl(1'b0, 1'b1, "drop_after_tick");
  endtask

  task automatic test_blink();
    mode = 2'b01; pos_x = 10'd272; pos_y = 10'd200;
    ctl(1'b1, 1'b0, "blink_restart");
    for (int t = 1; t <= 62; t++) begin
      ctl(1'b0, 1'b1, "blink_tick");
      if (t % 5 == 0 || (t >= 29 && t <= 31) || t >= 59) probe(272, 204, "blink_pixel");
    end
  endtask

  task automatic test_blink_slide();
    int n;
    mode = 2'b11; pos_x = 10'd272; pos_y = 10'd200;
    ctl(1'b1, 1'b0, "bslide_restart");
    n = 0;
    while (m_busy == 1 && n < 200) begin
      ctl(1'b0, 1'b1, "bslide_tick");
      n++;
      if (n % 15 == 0) probe(m_cur, 204, "bslide_visible");
    end
    for (int t = 1; t <= 31; t++) begin
      ctl(1'b0, 1'b1, "bslide_blink_tick");
      if (t >= 28) probe(272, 204, "bslide_blink_pixel");
    end
  endtask

  task automatic test_reset_mid_slide();
    mode = 2'b10; pos_x = 10'd272; pos_y = 10'd200;
    ctl(1'b1, 1'b0, "rst_restart");
    repeat (5) ctl(1'b0, 1'b1, "rst_tick");
    probe(m_cur, 204, "rst_pre_lit");
    #3;
    Reset_n = 1'b0;
    #1;
    m_cur = SCREEN_W; m_busy = 0; m_cnt = 0; m_vis = 1;
    checks++;
    if ({pixel_on, busy, done} !== 3'b000 || rom_bus.rom_addr !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: pixel_on/busy/done=%b%b%b rom_addr=%0d expected 000 and 0",
               pixel_on, busy, done, rom_bus.rom_addr);
    end
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    repeat (4) ctl(1'b0, 1'b1, "post_reset_tick");
    probe(640, 204, "post_reset_parked");
    probe(272, 204, "post_reset_offscreen");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < H; r++) rom[r] = {$urandom, $urandom, $urandom};
    rom[0] = '0;
    rom[2][W-1] = 1'b1;
    rom[15][0] = 1'b1;
    test_reset();
    test_static();
    test_scaling();
    test_negative();
    test_stream();
    test_slide();
    test_mode_drop();
    test_blink();
    test_blink_slide();
    test_reset_mid_slide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
